// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with hex decode, per-digit dp,
// anti-ghost blanking, double-buffered display load and a frame-start strobe.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking.
module seg_scan_driver #(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned DIV       = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic                  frame_start,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DIG_W = 4 * N_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [DIG_W-1:0]    shadow_dig;
    logic [N_DIGITS-1:0] shadow_dp;
    logic [DIG_W-1:0]    disp_dig;
    logic [N_DIGITS-1:0] disp_dp;
    logic                pending;

    logic                wrap_c;
    logic                boundary_c;
    logic                in_blank_c;
    logic [3:0]          cur_dig_c;
    logic                cur_dp_c;
    logic                cur_lz_c;
    logic [N_DIGITS-1:0] an_c;
    logic [7:0]          seg_c;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign wrap_c     = (cnt == CNT_LAST);
    assign boundary_c = wrap_c && (idx == '0);

    // Blank interval at the start of each slot (absent when BLANK_CYC is 0)
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank_c = 1'b0;
        end else begin : g_blank
            assign in_blank_c = (32'(cnt) < BLANK_CYC);
        end
    endgenerate

    // Slot prescaler and digit index, MS digit first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= IDX_TOP;
        end else if (wrap_c) begin
            cnt <= '0;
            idx <= (idx == '0) ? IDX_TOP : idx - IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Double buffer: loads land in shadow, display swaps only at frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
            disp_dig   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
            end
            if (boundary_c) begin
                if (load) begin
                    disp_dig <= digits_in;
                    disp_dp  <= dp_in;
                end else if (pending) begin
                    disp_dig <= shadow_dig;
                    disp_dp  <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Select current digit, anode pattern and leading-zero state
    always_comb begin
        cur_dig_c = 4'h0;
        cur_dp_c  = 1'b0;
        cur_lz_c  = 1'b0;
        an_c      = '1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_dig_c = disp_dig[4*k +: 4];
                cur_dp_c  = disp_dp[k];
                an_c[k]   = in_blank_c;
            end
        end
`ifdef SEG_LZB_EN
        begin
            logic run;
            run = 1'b1;
            for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
                run = run && (disp_dig[4*k +: 4] == 4'h0) && !disp_dp[k];
                if (idx == IDX_W'(k)) begin
                    cur_lz_c = run;
                end
            end
        end
`endif
        seg_c = cur_lz_c ? 8'hFF : {~cur_dp_c, hex7(cur_dig_c)};
    end

    // Registered pin outputs, one clk behind (idx, cnt)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= '1;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_c;
            seg         <= seg_c;
            frame_start <= (idx == IDX_TOP) && (cnt == '0);
        end
    end

endmodule
